// File: rtl/pc_unit_if.sv
// pc_unit_if: fetch/decode-side signal bundle of the program-counter unit
interface pc_unit_if;
    logic        imem_ready;
    logic [31:0] instr;
    logic [31:0] rs_data;
    logic        alu_zero;
    logic        Branch;
    logic [1:0]  Jump;
    logic        Exception;
    logic        irq_in;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [5:0]  opCode;
    logic [5:0]  funct;
    logic        pc31;
    logic        irq;
    logic        irq_ack;
    logic        cause;
    logic        commit;

    modport master (
        output imem_ready, instr, rs_data, alu_zero, Branch, Jump, Exception, irq_in,
        input  pc, pc_plus4, opCode, funct, pc31, irq, irq_ack, cause, commit
    );

    modport slave (
        input  imem_ready, instr, rs_data, alu_zero, Branch, Jump, Exception, irq_in,
        output pc, pc_plus4, opCode, funct, pc31, irq, irq_ack, cause, commit
    );
endinterface

// File: rtl/pc_unit.sv
// pc_unit: program counter, next-PC selection, interrupt sync/latch and fetch stall
module pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] IRQ_VEC  = 32'h8000_0080,
    parameter logic [31:0] EXC_VEC  = 32'h8000_0000
) (
    input logic     clk,
    input logic     reset,
    pc_unit_if.slave bus
);
    logic [31:0] pc_q, pc_d, pc_plus4, j_tgt, br_tgt;
    logic        s1_q, s2_q, s3_q;
    logic        pend_q, pend_d;
    logic        cause_q, cause_d;
    logic        take, br_taken;

    assign pc_plus4 = pc_q + 32'd4;
    assign j_tgt    = {pc_plus4[31:28], bus.instr[25:0], 2'b00};
    assign br_tgt   = pc_plus4 + {{14{bus.instr[15]}}, bus.instr[15:0], 2'b00};
    assign br_taken = bus.instr[26] ? ~bus.alu_zero : bus.alu_zero;
    // Interrupts are masked in kernel space (pc[31]) and during stalls
    assign take     = bus.imem_ready & pend_q & ~pc_q[31] & ~reset;

    // Next-PC priority: interrupt, exception, jr, j/jal, taken branch, sequential
    always_comb begin
        pc_d    = pc_q;
        cause_d = cause_q;
        if (bus.imem_ready) begin
            pc_d    = take                 ? IRQ_VEC :
                      bus.Exception        ? EXC_VEC :
                      bus.Jump == 2'b11    ? bus.rs_data :
                      bus.Jump == 2'b10    ? j_tgt :
                      (bus.Jump == 2'b01 && bus.Branch && br_taken) ? br_tgt : pc_plus4;
            cause_d = take ? 1'b1 : bus.Exception ? 1'b0 : cause_q;
        end
        pend_d = (s2_q & ~s3_q) | (pend_q & ~take);
    end

    // Architectural state, interrupt synchronizer and edge-detect flop
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            pend_q  <= 1'b0;
            cause_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            s1_q    <= bus.irq_in;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            pend_q  <= pend_d;
            cause_q <= cause_d;
        end
    end

    assign bus.pc       = pc_q;
    assign bus.pc_plus4 = pc_plus4;
    assign bus.opCode   = bus.instr[31:26];
    assign bus.funct    = bus.instr[5:0];
    assign bus.pc31     = pc_q[31];
    assign bus.irq      = pend_q;
    assign bus.irq_ack  = take;
    assign bus.cause    = cause_q;
    assign bus.commit   = bus.imem_ready & ~reset;
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed vectors with hand-computed expectations for pc_unit
module tb_pc_unit;
    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    localparam logic [31:0] IRQ_VEC = 32'h8000_0080;
    localparam logic [31:0] EXC_VEC = 32'h8000_0000;

    pc_unit_if bus ();

    pc_unit dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go_to(input logic [31:0] addr);
        bus.Jump    = 2'b11;
        bus.rs_data = addr;
        tick();
        bus.Jump    = 2'b00;
    endtask

    initial begin
        reset          = 1'b1;
        bus.imem_ready = 1'b1;
        bus.instr      = 32'h0;
        bus.rs_data    = 32'h0;
        bus.alu_zero   = 1'b0;
        bus.Branch     = 1'b0;
        bus.Jump       = 2'b00;
        bus.Exception  = 1'b0;
        bus.irq_in     = 1'b0;
        tick();
        tick();
        check("rst_pc", bus.pc, 32'h0);
        check("rst_irq", 32'(bus.irq), 32'h0);
        check("rst_cause", 32'(bus.cause), 32'h0);
        check("rst_commit", 32'(bus.commit), 32'h0);
        check("rst_ack", 32'(bus.irq_ack), 32'h0);
        reset = 1'b0;
        #1;
        check("commit", 32'(bus.commit), 32'h1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("seq", bus.pc, 32'(4 * i));
        end
        bus.instr = 32'hAC00_002A;
        #1;
        check("pc_plus4", bus.pc_plus4, 32'd16);
        check("opCode", 32'(bus.opCode), 32'h2B);
        check("funct", 32'(bus.funct), 32'h2A);
        // branches
        go_to(32'h100);
        bus.Jump = 2'b01; bus.Branch = 1'b1;
        bus.instr = {6'h04, 10'h0, 16'hFFFF}; bus.alu_zero = 1'b1;
        tick();
        check("beq_taken", bus.pc, 32'h100);
        bus.alu_zero = 1'b0;
        tick();
        check("beq_not", bus.pc, 32'h104);
        bus.Jump = 2'b00;
        go_to(32'h100);
        bus.Jump = 2'b01; bus.instr = {6'h05, 10'h0, 16'h0003}; bus.alu_zero = 1'b0;
        tick();
        check("bne_taken", bus.pc, 32'h110);
        bus.alu_zero = 1'b1;
        tick();
        check("bne_not", bus.pc, 32'h114);
        bus.Branch = 1'b0; bus.alu_zero = 1'b0;
        tick();
        check("br_nobranch", bus.pc, 32'h118);
        bus.Jump = 2'b00;
        // jumps
        go_to(32'h10);
        bus.Jump = 2'b10; bus.instr = {6'h02, 26'h0000040};
        tick();
        check("j", bus.pc, 32'h100);
        bus.Jump = 2'b00;
        go_to(32'h9000_0000);
        bus.Jump = 2'b10;
        tick();
        check("j_region", bus.pc, 32'h9000_0100);
        go_to(32'h2000);
        check("jr", bus.pc, 32'h2000);
        go_to(32'hFFFF_FFFC);
        tick();
        check("wrap", bus.pc, 32'h0);
        // interrupt latency
        go_to(32'h40);
        bus.irq_in = 1'b1;
        tick();
        bus.irq_in = 1'b0;
        check("irq_e0", 32'(bus.irq), 32'h0);
        tick();
        check("irq_e1", 32'(bus.irq), 32'h0);
        tick();
        check("irq_e2", 32'(bus.irq), 32'h1);
        check("ack_e2", 32'(bus.irq_ack), 32'h1);
        check("pc_e2", bus.pc, 32'h4C);
        tick();
        check("vec_pc", bus.pc, IRQ_VEC);
        check("vec_cause", 32'(bus.cause), 32'h1);
        check("vec_irq", 32'(bus.irq), 32'h0);
        check("vec_ack", 32'(bus.irq_ack), 32'h0);
        check("vec_pc31", 32'(bus.pc31), 32'h1);
        // masked in kernel space
        bus.irq_in = 1'b1;
        tick();
        bus.irq_in = 1'b0;
        tick();
        tick();
        tick();
        check("mask_irq", 32'(bus.irq), 32'h1);
        check("mask_ack", 32'(bus.irq_ack), 32'h0);
        check("mask_pc", bus.pc, 32'h8000_0090);
        go_to(32'h44);
        check("ret_pc", bus.pc, 32'h44);
        check("ret_ack", 32'(bus.irq_ack), 32'h1);
        tick();
        check("ret_vec", bus.pc, IRQ_VEC);
        // exception in kernel mode
        bus.Exception = 1'b1;
        tick();
        bus.Exception = 1'b0;
        check("exc_pc", bus.pc, EXC_VEC);
        check("exc_cause", 32'(bus.cause), 32'h0);
        // pending while in kernel, then stall in user space
        bus.irq_in = 1'b1;
        tick();
        bus.irq_in = 1'b0;
        tick();
        tick();
        check("pend_k", 32'(bus.irq), 32'h1);
        go_to(32'h200);
        check("pend_user", 32'(bus.irq), 32'h1);
        bus.imem_ready = 1'b0; bus.Exception = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_ack", 32'(bus.irq_ack), 32'h0);
            check("stall_commit", 32'(bus.commit), 32'h0);
            tick();
            check("stall_pc", bus.pc, 32'h200);
            check("stall_cause", 32'(bus.cause), 32'h0);
            check("stall_irq", 32'(bus.irq), 32'h1);
        end
        bus.imem_ready = 1'b1;
        #1;
        check("prio_ack", 32'(bus.irq_ack), 32'h1);
        tick();
        bus.Exception = 1'b0;
        check("prio_pc", bus.pc, IRQ_VEC);
        check("prio_cause", 32'(bus.cause), 32'h1);
        // reset during stall with pending set
        go_to(32'h300);
        bus.irq_in = 1'b1;
        tick();
        bus.irq_in = 1'b0;
        tick();
        bus.imem_ready = 1'b0;
        tick();
        check("pre_rst_irq", 32'(bus.irq), 32'h1);
        check("pre_rst_pc", bus.pc, 32'h308);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.imem_ready = 1'b1;
        check("mid_rst_pc", bus.pc, 32'h0);
        check("mid_rst_irq", 32'(bus.irq), 32'h0);
        check("mid_rst_cause", 32'(bus.cause), 32'h0);
        tick();
        tick();
        check("post_rst_pc", bus.pc, 32'h8);
        check("post_rst_irq", 32'(bus.irq), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pc_unit.md
# pc_unit

Program-counter and fetch sequencer for the single-cycle MIPS-subset core. It holds the architectural PC, feeds the fetched instruction's `opCode`/`funct` and the kernel-mode flag `pc31` to the control decoder, and consumes the decoder's `Branch`/`Jump`/`Exception` outputs to select the next PC. It also synchronizes and latches the external interrupt, presents it to the decoder as `irq`, and stalls on instruction-memory wait states.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `IRQ_VEC`, 32'h8000_0080: interrupt handler address.
- `EXC_VEC`, 32'h8000_0000: exception handler address.

- `clk`  in  1  core clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `imem_ready`  in  1  instruction memory has valid `instr` for the current `pc`.
- `instr`  in  32  fetched instruction word.
- `rs_data`  in  32  register-file rs read value, used as the `jr` target.
- `alu_zero`  in  1  ALU zero flag, used for branch resolution.
- `Branch`  in  1  from decoder.
- `Jump`  in  2  from decoder: 00 seq, 01 branch, 10 j/jal, 11 jr.
- `Exception`  in  1  from decoder.
- `irq_in`  in  1  asynchronous external interrupt request, level.
- `pc`  out  32  current PC, which is also the imem address.
- `pc_plus4`  out  32  `pc + 4`, mod 2^32; the return address for jal and the vectoring paths.
- `opCode`  out  6  `instr[31:26]`.
- `funct`  out  6  `instr[5:0]`.
- `pc31`  out  1  `pc[31]`, the kernel-mode flag.
- `irq`  out  1  pending interrupt, to the decoder.
- `irq_ack`  out  1  one-cycle pulse when the interrupt vector is taken.
- `cause`  out  1  last vector cause: 1 = interrupt, 0 = exception.
- `commit`  out  1  the current instruction retires on this edge. Equals `imem_ready & ~reset`.

## Operation
- Next-PC selection applies only when `imem_ready`=1. It is evaluated in priority order; the first match wins:
  1. `irq & ~pc31`: next PC is `IRQ_VEC`; `cause`<=1; `irq_ack`=1; pending is cleared.
  2. `Exception`: next PC is `EXC_VEC`; `cause`<=0.
  3. `Jump`=11: next PC is `rs_data`.
  4. `Jump`=10: next PC is `{pc_plus4[31:28], instr[25:0], 2'b00}`.
  5. `Jump`=01 and `Branch` and taken: next PC is `pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00}`.
     - Taken means `instr[26] ? ~alu_zero : alu_zero` (bne / beq).
  6. Otherwise: next PC is `pc_plus4`.
- All adds are 32-bit and wrap modulo 2^32. No alignment check is made on the `jr` target; it is loaded verbatim.
- Stall (`imem_ready`=0):
  - `pc`, `cause` and the pending flag hold (except that a new edge may still set pending).
  - No interrupt is taken; `irq_ack`=0; `commit`=0.
  - Decoder outputs are ignored, including any `Exception` decoded from stale `instr`.
- Interrupt path:
  - `irq_in` passes through a two-flop synchronizer (`s1`, `s2`) followed by a delay flop `s3`.
  - A rising edge is `s2 & ~s3`; it sets pending.
  - Pending clears only when the interrupt is taken.
  - Set and clear on the same edge: set wins, so pending stays 1.
  - `irq` = pending. It stays asserted while `pc31`=1 (interrupts are masked in kernel space) until the handler returns via `jr` to an address with bit 31 clear.
- Mode: there is no separate mode register; kernel mode is exactly `pc[31]`.

## Timing
- Reset values: `pc`=`RESET_PC`; `s1`/`s2`/`s3`=0; pending=0; `cause`=0; `irq_ack`=0.
  - Because pending=0, `irq`=0 and `commit`=0 during reset.
- Reset asserted mid-stall or mid-pending discards all of that state on the next edge.
- `pc` updates on the rising edge. `opCode`, `funct`, `pc_plus4`, `pc31` and `irq` are combinational from registered state and `instr`.
- Interrupt latency, with `irq_in` rising before edge E0:
  - `s1`=1 after E0.
  - `s2`=1 after E1.
  - pending=1 after E2.
  - Vector taken at E3 (`pc`=`IRQ_VEC` after E3) if `~pc31` and `imem_ready` at E3. Otherwise it is taken at the first later edge meeting both conditions.
- `irq_ack` is high during the cycle the take condition holds; it is combinational and the edge consumes it.
- `irq_in` held high generates only one pending event; it must fall and rise again to produce another.

## Test plan
- Reset and sequential fetch:
  - Reset for 2 cycles -> `pc`=0, `irq`=0, `cause`=0.
  - Release with `imem_ready`=1, `Jump`=00 -> `pc` goes 0, 4, 8, 12 on successive edges.
- Branches at `pc`=0x100:
  - beq (`instr[26]`=0), imm=0xFFFF, `alu_zero`=1 -> `pc`=0x100.
  - Same with `alu_zero`=0 -> `pc`=0x104.
  - bne (`instr[26]`=1), imm=0x0003, `alu_zero`=0 -> `pc`=0x110.
- Jumps:
  - At `pc`=0x0000_0010, `Jump`=10, `instr[25:0]`=0x0000040 -> `pc`=0x0000_0100.
  - `Jump`=11, `rs_data`=0x0000_2000 -> `pc`=0x0000_2000.
  - At `pc`=0xFFFF_FFFC, sequential step -> `pc`=0x0000_0000 (wrap).
- Interrupt:
  - Pulse `irq_in` high at cycle 0 with `pc`=0x40 -> `irq`=1 after edge 2.
  - At edge 3 -> `pc`=0x8000_0080, `cause`=1, `irq_ack` pulse, `irq`=0.
  - Second `irq_in` pulse while `pc31`=1 -> `irq` stays 1, no vector taken.
  - `jr` to 0x44 -> vector taken on the next edge.
- Exception vs interrupt vs stall:
  - `Exception`=1 with pending=1 and `pc31`=0 -> `IRQ_VEC`, `cause`=1.
  - `Exception`=1 with `pc31`=1 -> `pc`=0x8000_0000, `cause`=0.
  - `imem_ready`=0 for 3 cycles with `Exception`=1 and pending=1 -> `pc`, `cause` and pending unchanged; `irq_ack`=0.
- Reset mid-operation:
  - Assert reset one cycle after pending sets, during a stall -> next edge `pc`=`RESET_PC`, `irq`=0, and no vector is taken after release.
